// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared architectural constants for the fetch path: NOP encoding and the instruction-type field.
package fetch_prefetch_queue_pkg;

  localparam int unsigned ArchInstrWidth = 32;
  localparam logic [ArchInstrWidth-1:0] ArchNop = 32'h0000_0000;

  localparam int unsigned InstrTypeLsb   = 0;
  localparam int unsigned InstrTypeWidth = 7;

  function automatic logic [InstrTypeWidth-1:0] instr_type(input logic [ArchInstrWidth-1:0] word);
    return word[InstrTypeLsb +: InstrTypeWidth];
  endfunction

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// Memory read port, redirect and decode handshake signals of the fetch stage.
interface fetch_prefetch_queue_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  instr_ready;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;

  modport master (
    output mem_raddr,
    input  mem_rdata,
    input  redirect_valid,
    input  redirect_addr,
    input  instr_ready,
    output instr_valid,
    output instr,
    output instr_pc
  );

  modport slave (
    input  mem_raddr,
    output mem_rdata,
    output redirect_valid,
    output redirect_addr,
    output instr_ready,
    input  instr_valid,
    input  instr,
    input  instr_pc
  );

endinterface

// File: rtl/fetch_prefetch_queue_prefetch_fifo.sv
// Circular prefetch buffer with push/pop/flush; flush wins over everything else.
module fetch_prefetch_queue_prefetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrWidth = $clog2(DEPTH);
  localparam int unsigned CntWidth = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0] count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
      if (push_i && !pop_i) begin
        count_d = count_q + CntWidth'(1);
      end else if (pop_i && !push_i) begin
        count_d = count_q - CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntWidth'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch stage: owns the fetch PC, prefetches sequential words and presents the oldest to decode.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  fetch_prefetch_queue_if.master  bus
);

  import fetch_prefetch_queue_pkg::*;

  localparam int unsigned EntryWidth = ADDR_WIDTH + DATA_WIDTH;

  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [EntryWidth-1:0] head;
  logic [ADDR_WIDTH-1:0] head_pc;
  logic [DATA_WIDTH-1:0] head_word;
  logic                  push, pop, full, empty;

  // Redirect suppresses both queue operations; a full queue may still push if it pops.
  always_comb begin
    pop        = !empty && bus.instr_ready && !bus.redirect_valid;
    push       = !bus.redirect_valid && (!full || pop);
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_addr;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_prefetch_queue_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EntryWidth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .wdata_i ({fetch_pc_q, bus.mem_rdata}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign {head_pc, head_word} = head;

  assign bus.mem_raddr   = fetch_pc_q;
  assign bus.instr_valid = !empty;
  assign bus.instr       = empty ? DATA_WIDTH'(ArchNop) : head_word;
  assign bus.instr_pc    = empty ? '0 : head_pc;

endmodule

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction fetch stage placed between the dual-port main memory's instruction read port and the issue register of the pipelined core. It owns the fetch PC, streams sequential instruction words into a small FIFO, and presents the oldest entry to the decode stage with a valid/ready handshake. When issue stalls, prefetching continues until the queue is full. On a taken jump it flushes the queue and restarts fetch at the jump target.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- ADDR_WIDTH, 32, fetch PC / word address width
- DATA_WIDTH, 32, instruction word width
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- mem_raddr  output  ADDR_WIDTH  word address to memory read port 0; combinational read
- mem_rdata  input  DATA_WIDTH  instruction word at mem_raddr, same cycle
- redirect_valid  input  1  taken jump; flush and restart
- redirect_addr  input  ADDR_WIDTH  jump target word address
- instr_ready  input  1  issue register accepts head this cycle (low = stall)
- instr_valid  output  1  head entry valid
- instr  output  DATA_WIDTH  head instruction; 32'h0 (NOP) when empty
- instr_pc  output  ADDR_WIDTH  address of head instruction; 0 when empty

## Operation
- State: fetch_pc, storage array of {pc, word}, rd_ptr, wr_ptr (log2 DEPTH bits, wrap modulo DEPTH), count (log2(DEPTH+1) bits).
- mem_raddr = fetch_pc at all times.
- pop = instr_valid && instr_ready && !redirect_valid.
- push = !redirect_valid && (count < DEPTH || pop). Push writes {fetch_pc, mem_rdata} at wr_ptr, then fetch_pc += 1 (wraps at 2^ADDR_WIDTH).
- count_next = count + push − pop. Push and pop in the same cycle leave count unchanged, including when full.
- Redirect has highest priority. On the clock edge with redirect_valid = 1, count, rd_ptr, and wr_ptr go to 0 and fetch_pc takes redirect_addr. There is no push and no pop that cycle, even if instr_ready = 1.
- The consumer must not assume a pop when redirect_valid is asserted.
- instr_valid = (count != 0). instr/instr_pc come from the head entry when valid, otherwise 0.
- Reset: fetch_pc = 0, count = 0, pointers = 0, instr_valid = 0, instr = 0, instr_pc = 0. Storage contents need no reset.

## Timing
- Fetch latency is 1 cycle: a word addressed in cycle N is visible at the head in cycle N+1 if the queue was empty.
- After reset deassertion, the first edge pushes address 0. instr_valid rises after that edge.
- Redirect penalty: the edge with redirect empties the queue; the next edge pushes redirect_addr; instr_valid returns one cycle later.
- Sustained throughput is 1 instruction per cycle while instr_ready = 1.
- Full with instr_ready = 0: fetch_pc holds and mem_raddr is stable.
- Reset asserted mid-operation immediately clears all outputs (asynchronous), whatever the queue state.
- All outputs except mem_raddr are registered-state-derived. There is no combinational path from instr_ready or redirect_valid to any output.

## Structure
- NOP encoding (32'h0) and the instruction-type field position go in the shared arch_defines include. Do not hard-code them locally.
- One natural sub-module: prefetch_fifo, a parameterised storage array with pointer/count logic and push/pop/flush inputs.
- The top level holds fetch_pc, the push/pop/redirect priority, and the output muxing.

## Test plan
- Reset, then instr_ready = 1, memory[i] = i+100 → instr_valid rises one cycle after the first edge; instr sequence is 100, 101, 102… with instr_pc 0, 1, 2…, one per cycle.
- instr_ready = 0 from the start → count saturates at 4 after 4 edges; mem_raddr holds at 4. Raising ready then drains 100..103 and continues at 104 with no gap.
- Full queue with instr_ready = 1 for one cycle → one pop and one push in the same edge; count stays 4; next fetched pc is 5.
- redirect_valid with redirect_addr = 40 while 3 entries are queued and instr_ready = 1 → no pop; queue empties, instr = 0. The next edge fetches 40, and instr_pc = 40 appears one cycle later.
- Redirect during reset-release edge / redirect every cycle → instr_valid stays 0; fetch_pc follows each redirect_addr.
- rst asserted with 2 entries queued → instr_valid, instr, and instr_pc go to 0 immediately. After release, fetch restarts at 0.
